dmrs_ls_estimator: RTL and testbench
====================================

Name: dmrs_ls_estimator

Overview:
- Receiver-side consumer of the PUSCH DMRS stream produced by the DMRS generator.
- For each DMRS subcarrier, takes the locally generated reference sample X and the received pilot sample Y, and computes the least-squares channel estimate H = Y·conj(X), rounded and saturated.
- Sits between the RX resource demapper, which supplies Y aligned to DMRS_valid, and the equaliser.
- Tracks the symbol boundary and checks that the sample count matches the allocation.

Parameters:
- WIDTH, 9, signed bit width of the DMRS and received I/Q samples (full scale ±2^(WIDTH-1)).
- OUT_WIDTH, 11, signed bit width of the channel estimate outputs.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- N_rb  input  7  allocated RBs; expected sample count = 6*N_rb
- DMRS_r  input  WIDTH  reference sample, real (signed)
- DMRS_i  input  WIDTH  reference sample, imaginary (signed)
- DMRS_valid  input  1  DMRS_r/i and Rx_r/i valid this cycle
- DMRS_finished  input  1  one-cycle pulse: last sample of symbol sent (on or after last valid)
- Rx_r  input  WIDTH  received pilot, real (signed), aligned with DMRS_valid
- Rx_i  input  WIDTH  received pilot, imaginary (signed)
- H_r  output  OUT_WIDTH  estimate, real (signed)
- H_i  output  OUT_WIDTH  estimate, imaginary (signed)
- H_valid  output  1  H_r/H_i valid
- est_done  output  1  one-cycle pulse: symbol estimate complete
- est_busy  output  1  high in RUN or FLUSH
- cnt_err  output  1  sticky count mismatch for the last symbol

Behaviour:
- Interface: the one clock is clk; reset is asynchronous and active-high. Asserting reset clears all registers immediately. All outputs reset to 0 and the FSM returns to IDLE.
- Pipeline, 3 stages, fixed latency 3 cycles from DMRS_valid to H_valid. There is no backpressure, and one sample per cycle is accepted.
  - S1: register X, Y and valid.
  - S2: compute the four WIDTH×WIDTH signed products (2*WIDTH bits each).
  - S3: compute the two sums and round, saturate and register.
- Arithmetic:
  - Pr = Yr*Xr + Yi*Xi; Pi = Yi*Xr − Yr*Xi, each 2*WIDTH+1 bits.
  - Round: add 2^(WIDTH−2), then arithmetic shift right by WIDTH−1.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- H_r/H_i hold their last value when H_valid=0.
- FSM:
  - IDLE: on DMRS_valid → RUN. Capture N_rb, clear the sample counter (10 bits), clear cnt_err. Count this sample.
  - RUN: count every DMRS_valid. On DMRS_finished → FLUSH, including when it coincides with a valid, which is counted.
  - FLUSH: DMRS_valid is ignored (not counted, not pushed into the pipeline). Stay for 3 cycles, then pulse est_done and return to IDLE.
- Timing of est_done: asserted exactly 3 cycles after DMRS_finished is sampled. If finished coincides with the last valid, est_done coincides with the last H_valid.
- DMRS_finished in IDLE with no preceding valid: ignored, no est_done.
- Count check: on entry to FLUSH, compare the count with 6*captured N_rb; set cnt_err on mismatch. cnt_err updates in the same cycle est_done pulses and holds until the next IDLE→RUN.
- Counter saturates at 1023; it does not wrap.
- est_busy = (state != IDLE).

Optional Feature:
- Macro: DMRS_CNT_CHECK_EN.
- Defined: sample counter, N_rb capture and cnt_err logic are as described above.
- Undefined: no counter or comparator; cnt_err is tied to 0. FSM, est_done and the datapath are unchanged.

Test Plan:
- Y=(100,0), X=(255,0), single valid plus finished in the same cycle → 3 cycles later H=(100,0), H_valid=1, est_done=1.
- Y=(0,100), X=(0,255) → H=(100,0); Y=(100,0), X=(0,255) → H=(0,−100).
- OUT_WIDTH=8, Y=(255,255), X=(255,255) → H_r saturates to 127, H_i=0.
- Count check:
  - N_rb=2, 12 consecutive valids then finished → est_done pulse, cnt_err=0.
  - 11 valids then finished → cnt_err=1 with macro defined, 0 without.
- Reset mid-symbol: assert reset after 5 valids → H_valid, est_busy and est_done go to 0 immediately. A new symbol then estimates normally with a fresh count.
- DMRS_valid during FLUSH and DMRS_finished in IDLE → no extra H_valid, no est_done, count unaffected.

Source files
------------

// File: rtl/dmrs_ls_estimator.sv
// dmrs_ls_estimator: least-squares channel estimate H = Y * conj(X) for one
// PUSCH DMRS symbol. The datapath is a 3-stage pipeline that accepts one sample
// per cycle. A small FSM tracks the symbol boundary and the 3-cycle flush.
// Optional feature macro: DMRS_CNT_CHECK_EN. When it is defined, the block
// checks the per-symbol sample count against 6*N_rb and reports the result on
// cnt_err. When it is undefined, cnt_err is always 0.
module dmrs_ls_estimator #(
    parameter int WIDTH     = 9,
    parameter int OUT_WIDTH = 11
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [6:0]                  N_rb,
    input  logic signed [WIDTH-1:0]     DMRS_r,
    input  logic signed [WIDTH-1:0]     DMRS_i,
    input  logic                        DMRS_valid,
    input  logic                        DMRS_finished,
    input  logic signed [WIDTH-1:0]     Rx_r,
    input  logic signed [WIDTH-1:0]     Rx_i,
    output logic signed [OUT_WIDTH-1:0] H_r,
    output logic signed [OUT_WIDTH-1:0] H_i,
    output logic                        H_valid,
    output logic                        est_done,
    output logic                        est_busy,
    output logic                        cnt_err
);

    localparam int PW = 2*WIDTH + 1;
    localparam logic signed [PW-1:0] RND_ADD = {{(PW-1){1'b0}}, 1'b1} << (WIDTH-2);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Full-width signed product of two samples.
    function automatic logic signed [2*WIDTH-1:0] smul(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ea;
        logic signed [2*WIDTH-1:0] eb;
        ea = {{WIDTH{a[WIDTH-1]}}, a};
        eb = {{WIDTH{b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    // Sign-extend a product by one bit so that a sum of two products cannot overflow.
    function automatic logic signed [PW-1:0] sext_prod(input logic signed [2*WIDTH-1:0] p);
        return {p[2*WIDTH-1], p};
    endfunction

    // Round half up at bit WIDTH-2, then drop the WIDTH-1 fraction bits and clamp.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] r;
        r = (v + RND_ADD) >>> (WIDTH-1);
        if (r > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            return r[OUT_WIDTH-1:0];
        end
    endfunction

    state_t      state_r, next_state_s;
    logic [1:0]  flush_cnt_r;
    logic        accept_s, start_s, done_s, flush_entry_s;
    logic        est_done_r, est_busy_r;

    logic signed [WIDTH-1:0]   xr_r, xi_r, yr_r, yi_r;
    logic                      s1_valid_r;
    logic signed [2*WIDTH-1:0] prod_rr_r, prod_ii_r, prod_ir_r, prod_ri_r;
    logic                      s2_valid_r;
    logic signed [PW-1:0]      sum_r_s, sum_i_s;
    logic signed [OUT_WIDTH-1:0] h_r_r, h_i_r;
    logic                      h_valid_r;

    // Next-state and sample-acceptance decode; FLUSH drops any incoming valid.
    always_comb begin
        next_state_s  = state_r;
        accept_s      = 1'b0;
        start_s       = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = DMRS_valid;
                start_s  = DMRS_valid;
                if (DMRS_valid) begin
                    if (DMRS_finished) begin
                        next_state_s = ST_FLUSH;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                accept_s = DMRS_valid;
                if (DMRS_finished) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                done_s = (flush_cnt_r == 2'd1);
                if (flush_cnt_r == 2'd2) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        flush_entry_s = (state_r != ST_FLUSH) && (next_state_s == ST_FLUSH);
    end

    // State register, flush timer and the registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= 2'd0;
            est_done_r  <= 1'b0;
            est_busy_r  <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            flush_cnt_r <= (state_r == ST_FLUSH) ? flush_cnt_r + 2'd1 : 2'd0;
            est_done_r  <= done_s;
            est_busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    // Stage 1: capture reference and received samples of accepted cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xr_r       <= '0;
            xi_r       <= '0;
            yr_r       <= '0;
            yi_r       <= '0;
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                xr_r <= DMRS_r;
                xi_r <= DMRS_i;
                yr_r <= Rx_r;
                yi_r <= Rx_i;
            end
        end
    end

    // Stage 2: the four cross products of Y and X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_rr_r  <= '0;
            prod_ii_r  <= '0;
            prod_ir_r  <= '0;
            prod_ri_r  <= '0;
            s2_valid_r <= 1'b0;
        end else begin
            prod_rr_r  <= smul(yr_r, xr_r);
            prod_ii_r  <= smul(yi_r, xi_r);
            prod_ir_r  <= smul(yi_r, xr_r);
            prod_ri_r  <= smul(yr_r, xi_r);
            s2_valid_r <= s1_valid_r;
        end
    end

    // Stage 3 combine: Y*conj(X) real and imaginary parts.
    always_comb begin
        sum_r_s = sext_prod(prod_rr_r) + sext_prod(prod_ii_r);
        sum_i_s = sext_prod(prod_ir_r) - sext_prod(prod_ri_r);
    end

    // Stage 3 register: round and saturate; hold the estimate between valid samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_r_r     <= '0;
            h_i_r     <= '0;
            h_valid_r <= 1'b0;
        end else begin
            h_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                h_r_r <= round_sat(sum_r_s);
                h_i_r <= round_sat(sum_i_s);
            end
        end
    end

`ifdef DMRS_CNT_CHECK_EN
    // 6*n computed as 4n + 2n.
    function automatic logic [9:0] times6(input logic [6:0] n);
        return {1'b0, n, 2'b00} + {2'b00, n, 1'b0};
    endfunction

    logic [9:0] sample_cnt_r, cnt_next_s, expected_s;
    logic [6:0] nrb_r;
    logic       mismatch_r, cnt_err_r;

    // Next sample count (restart on a new symbol, saturating at 1023) and the target.
    always_comb begin
        cnt_next_s = sample_cnt_r;
        expected_s = times6(nrb_r);
        if (start_s) begin
            cnt_next_s = 10'd1;
            expected_s = times6(N_rb);
        end else if (accept_s) begin
            if (sample_cnt_r != 10'h3FF) begin
                cnt_next_s = sample_cnt_r + 10'd1;
            end else begin
                cnt_next_s = sample_cnt_r;
            end
        end else begin
            cnt_next_s = sample_cnt_r;
        end
    end

    // Count, compare on FLUSH entry, publish the verdict alongside est_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt_r <= 10'd0;
            nrb_r        <= 7'd0;
            mismatch_r   <= 1'b0;
            cnt_err_r    <= 1'b0;
        end else begin
            sample_cnt_r <= cnt_next_s;
            if (start_s) begin
                nrb_r <= N_rb;
            end
            if (flush_entry_s) begin
                mismatch_r <= (cnt_next_s != expected_s);
            end
            if (start_s) begin
                cnt_err_r <= 1'b0;
            end else if (done_s) begin
                cnt_err_r <= mismatch_r;
            end
        end
    end

    assign cnt_err = cnt_err_r;
`else
    // Without the count check N_rb has no consumer; fold it into a constant zero.
    assign cnt_err = (^N_rb) & 1'b0;
`endif

    assign H_r      = h_r_r;
    assign H_i      = h_i_r;
    assign H_valid  = h_valid_r;
    assign est_done = est_done_r;
    assign est_busy = est_busy_r;

endmodule

// File: tb/tb_dmrs_ls_estimator.sv
// Self-checking bench for dmrs_ls_estimator. It compares the default instance
// and a narrow-output (OUT_WIDTH=8) instance against a per-edge reference
// model. The model works on symbols and sample counts, not on RTL state.
module tb_dmrs_ls_estimator;

    localparam int W   = 9;
    localparam int OW  = 11;
    localparam int OWS = 8;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] n_rb;
    logic signed [W-1:0] dr, di, rr, ri;
    logic dv, df;

    logic signed [OW-1:0]  h_r, h_i;
    logic                  h_valid, est_done, est_busy, cnt_err;
    logic signed [OWS-1:0] h8_r, h8_i;
    logic                  h8_valid, est8_done, est8_busy, cnt8_err;

    dmrs_ls_estimator #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
        .clk(clk), .reset(reset), .N_rb(n_rb),
        .DMRS_r(dr), .DMRS_i(di), .DMRS_valid(dv), .DMRS_finished(df),
        .Rx_r(rr), .Rx_i(ri),
        .H_r(h_r), .H_i(h_i), .H_valid(h_valid),
        .est_done(est_done), .est_busy(est_busy), .cnt_err(cnt_err)
    );

    dmrs_ls_estimator #(.WIDTH(W), .OUT_WIDTH(OWS)) dut_sat (
        .clk(clk), .reset(reset), .N_rb(n_rb),
        .DMRS_r(dr), .DMRS_i(di), .DMRS_valid(dv), .DMRS_finished(df),
        .Rx_r(rr), .Rx_i(ri),
        .H_r(h8_r), .H_i(h8_i), .H_valid(h8_valid),
        .est_done(est8_done), .est_busy(est8_busy), .cnt_err(cnt8_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: H = Y*conj(X), rounded half up after scaling by 2^(W-1), clamped to ow bits.
    function automatic int ref_est(input int yr_v, input int yi_v, input int xr_v, input int xi_v,
                                   input bit imag, input int ow);
        int p, r, mx, mn;
        p  = imag ? (yi_v*xr_v - yr_v*xi_v) : (yr_v*xr_v + yi_v*xi_v);
        r  = (p + (1 << (W-2))) >>> (W-1);
        mx = (1 << (ow-1)) - 1;
        mn = -(1 << (ow-1));
        if (r > mx) return mx;
        if (r < mn) return mn;
        return r;
    endfunction

    function automatic int rs();
        return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W-1));
    endfunction

    typedef struct {
        int due;
        int hr, hi, hr8, hi8;
    } exp_t;

    exp_t q[$];
    int  edge_n = 0;
    int  mode   = 0;      // 0 idle, 1 collecting a symbol, 2 finishing
    int  fin_edge = 0;
    int  count  = 0;
    int  nrb    = 0;
    bit  exp_err  = 1'b0;
    bit  pend_err = 1'b0;
    int  last_hr = 0, last_hi = 0, last_hr8 = 0, last_hi8 = 0;

    task automatic push_sample(input int yr_v, input int yi_v, input int xr_v, input int xi_v);
        exp_t e;
        e.due = edge_n + 2;
        e.hr  = ref_est(yr_v, yi_v, xr_v, xi_v, 1'b0, OW);
        e.hi  = ref_est(yr_v, yi_v, xr_v, xi_v, 1'b1, OW);
        e.hr8 = ref_est(yr_v, yi_v, xr_v, xi_v, 1'b0, OWS);
        e.hi8 = ref_est(yr_v, yi_v, xr_v, xi_v, 1'b1, OWS);
        q.push_back(e);
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, compare 1 time unit later.
    task automatic cycle(input bit v, input bit f, input int yr_v, input int yi_v,
                         input int xr_v, input int xi_v);
        bit hv, xd;
        @(negedge clk);
        dv = v; df = f;
        rr = W'(yr_v); ri = W'(yi_v); dr = W'(xr_v); di = W'(xi_v);
        @(posedge clk);
        edge_n++;
        if (mode == 2) begin
            if (edge_n == fin_edge + 3) mode = 0;
        end else if (mode == 0) begin
            if (v) begin
                push_sample(yr_v, yi_v, xr_v, xi_v);
                count = 1; nrb = int'(n_rb); exp_err = 1'b0;
                if (f) begin
                    mode = 2; fin_edge = edge_n; pend_err = (count != 6*nrb);
                end else begin
                    mode = 1;
                end
            end
        end else begin
            if (v) begin
                push_sample(yr_v, yi_v, xr_v, xi_v);
                count = (count < 1023) ? count + 1 : 1023;
            end
            if (f) begin
                mode = 2; fin_edge = edge_n; pend_err = (count != 6*nrb);
            end
        end
        xd = (mode == 2) && (edge_n == fin_edge + 2);
`ifdef DMRS_CNT_CHECK_EN
        if (xd) exp_err = pend_err;
`endif
        hv = 1'b0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            hv = 1'b1;
            last_hr = q[0].hr; last_hi = q[0].hi; last_hr8 = q[0].hr8; last_hi8 = q[0].hi8;
            void'(q.pop_front());
        end
        #1;
        check("h_valid",  h_valid,  hv);
        check("h_r",      h_r,      last_hr);
        check("h_i",      h_i,      last_hi);
        check("h8_valid", h8_valid, hv);
        check("h8_r",     h8_r,     last_hr8);
        check("h8_i",     h8_i,     last_hi8);
        check("est_done", est_done, xd);
        check("est_busy", est_busy, mode != 0);
        check("cnt_err",  cnt_err,  exp_err);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, rs(), rs(), rs(), rs());
    endtask

    // One symbol of random samples with optional gaps, then valids during the flush window.
    task automatic run_symbol(input int nrb_v, input int nvalid, input bit fin_last,
                              input int gap_pct, input bit flush_noise);
        n_rb = 7'(nrb_v);
        for (int k = 0; k < nvalid; k++) begin
            if (int'($urandom_range(0, 99)) < gap_pct) cycle(1'b0, 1'b0, rs(), rs(), rs(), rs());
            cycle(1'b1, fin_last && (k == nvalid - 1), rs(), rs(), rs(), rs());
        end
        if (!fin_last || nvalid == 0) cycle(1'b0, 1'b1, rs(), rs(), rs(), rs());
        for (int k = 0; k < 3; k++) cycle(flush_noise, 1'b0, rs(), rs(), rs(), rs());
        idle(1);
    endtask

    // Reset asserted away from any clock edge; outputs must clear at once.
    task automatic reset_mid();
        @(negedge clk);
        dv = 1'b0; df = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_h_valid",  h_valid,  1'b0);
        check("rst_est_busy", est_busy, 1'b0);
        check("rst_est_done", est_done, 1'b0);
        check("rst_h_r",      h_r,      0);
        check("rst_cnt_err",  cnt_err,  1'b0);
        q.delete();
        mode = 0; exp_err = 1'b0;
        last_hr = 0; last_hi = 0; last_hr8 = 0; last_hi8 = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        dv = 1'b0; df = 1'b0; n_rb = 7'd0;
        dr = '0; di = '0; rr = '0; ri = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_h_valid",  h_valid,  1'b0);
        check("reset_est_busy", est_busy, 1'b0);
        check("reset_est_done", est_done, 1'b0);
        check("reset_cnt_err",  cnt_err,  1'b0);
        check("reset_h_i",      h_i,      0);
        reset = 1'b0;

        // Single sample with finish in the same cycle: expect (100,0) and est_done together.
        n_rb = 7'd1;
        cycle(1'b1, 1'b1, 100, 0, 255, 0);
        idle(5);

        // Quadrature cases plus the narrow-output saturation case and corners.
        cycle(1'b1, 1'b0, 0, 100, 0, 255);
        cycle(1'b1, 1'b0, 100, 0, 0, 255);
        cycle(1'b1, 1'b0, 255, 255, 255, 255);
        cycle(1'b1, 1'b0, -256, -256, -256, -256);
        cycle(1'b1, 1'b0, -256, 255, 255, -256);
        cycle(1'b1, 1'b1, 1, 1, 128, -128);
        idle(5);

        // Exact count, short count, count with a trailing finished pulse.
        run_symbol(2, 12, 1'b0, 0, 1'b0);
        run_symbol(2, 11, 1'b0, 0, 1'b0);
        run_symbol(2, 12, 1'b1, 0, 1'b1);
        run_symbol(1, 7,  1'b1, 0, 1'b0);

        // Reset after 5 valids, then a clean symbol with a fresh count.
        n_rb = 7'd1;
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, rs(), rs(), rs(), rs());
        reset_mid();
        run_symbol(1, 6, 1'b1, 0, 1'b0);

        // Valids during flush and a lone finished in idle must be ignored.
        run_symbol(1, 6, 1'b1, 0, 1'b1);
        cycle(1'b0, 1'b1, 0, 0, 0, 0);
        idle(4);
        run_symbol(1, 6, 1'b0, 0, 1'b0);

        // Counter saturation: 1786 samples would wrap to 762 = 6*127.
        n_rb = 7'd127;
        for (int k = 0; k < 1786; k++) cycle(1'b1, k == 1785, rs(), rs(), rs(), rs());
        idle(5);

        // Random symbols with gaps, off-by-one lengths and flush noise.
        for (int s = 0; s < 25; s++) begin
            int nr;
            nr = int'($urandom_range(1, 3));
            run_symbol(nr, 6*nr + int'($urandom_range(0, 2)) - 1, 1'($urandom_range(0, 1)),
                       20, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                cycle(1'b0, 1'b1, 0, 0, 0, 0);
                idle(1);
            end
        end
        idle(4);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
